// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder family.
// Pure declarations: no logic, no latency, no flow control.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic bit stages_valid(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) && (width % stages == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple slice: sum, carry out, and carry into its top bit.
// Zero latency; no flow control.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

    // The top sum bit is a^b^c, so the carry into it falls out of an XOR.
    assign c_msb_in = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/sub with carry/borrow-in, one carry-chain slice per register stage.
// Latency STAGES cycles, 1 beat/cycle; stalls all stages when out_valid && !out_ready.
// in_ready = !out_valid || out_ready; bubbles are carried, not collapsed.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int W_S = ceil_div(WIDTH, STAGES);

    if (!stages_valid(WIDTH, STAGES)) begin : g_bad_params
        $error("adder_pipe: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             advance;
    logic [WIDTH-1:0] b_prep;
    logic             c0;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction as A + ~B + ~Cin, so Cout reads as "no borrow".
    assign b_prep = (sub == SUB) ? ~B : B;
    assign c0     = (sub == SUB) ? ~Cin : Cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int UP = WIDTH - (k + 1) * W_S;

        logic [W_S-1:0]         a_sl, b_sl, s_sl;
        logic [(k+1)*W_S-1:0]   sum_d, sum_q;
        logic                   ci, co, vld_in;
        logic                   carry_q, vld_q;

        if (k == 0) begin : g_src
            assign a_sl   = A[W_S-1:0];
            assign b_sl   = b_prep[W_S-1:0];
            assign ci     = c0;
            assign vld_in = in_valid;
            assign sum_d  = s_sl;
        end else begin : g_src
            assign a_sl   = g_stage[k-1].g_ops.a_q[W_S-1:0];
            assign b_sl   = g_stage[k-1].g_ops.b_q[W_S-1:0];
            assign ci     = g_stage[k-1].carry_q;
            assign vld_in = g_stage[k-1].vld_q;
            assign sum_d  = {s_sl, g_stage[k-1].sum_q};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                vld_q   <= vld_in;
                carry_q <= co;
                sum_q   <= sum_d;
            end
        end

        // Operand bits still waiting for a later slice travel alongside the beat.
        if (UP > 0) begin : g_ops
            logic [UP-1:0] a_d, b_d, a_q, b_q;

            if (k == 0) begin : g_up
                assign a_d = A[WIDTH-1:W_S];
                assign b_d = b_prep[WIDTH-1:W_S];
            end else begin : g_up
                assign a_d = g_stage[k-1].g_ops.a_q[UP+W_S-1:W_S];
                assign b_d = g_stage[k-1].g_ops.b_q[UP+W_S-1:W_S];
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_out
            logic c_top, ovf_q;

            adder_slice #(.W(W_S)) u_slice (
                .a        (a_sl),
                .b        (b_sl),
                .ci       (ci),
                .s        (s_sl),
                .co       (co),
                .c_msb_in (c_top)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= c_top ^ co;
                end
            end

            assign out_valid = vld_q;
            assign Sum       = sum_q;
            assign Cout      = carry_q;
            assign Ovf       = ovf_q;
        end else begin : g_mid
            adder_slice #(.W(W_S)) u_slice (
                .a        (a_sl),
                .b        (b_sl),
                .ci       (ci),
                .s        (s_sl),
                .co       (co),
                .c_msb_in ()
            );
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench: directed WIDTH=8/STAGES=2 vectors and backpressure, plus exhaustive
// WIDTH=4 sweeps for STAGES 1, 2, 4 with random handshakes and a mid-stream reset.
module tb_adder_pipe;
    import adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: returns {cout, ovf, sum} packed from bit 0 up.
    function automatic logic [31:0] ref_result(input int w, input int a, input int b,
                                               input int cin, input int s);
        longint m    = longint'(1) << w;
        longint half = m / 2;
        longint sa   = (a >= half) ? a - m : a;
        longint sb   = (b >= half) ? b - m : b;
        longint u, r, sm;
        bit cout, ovf;
        if (s == 0) begin
            u    = longint'(a) + b + cin;
            r    = sa + sb + cin;
            cout = (u >= m);
        end else begin
            u    = longint'(a) - b - cin;
            r    = sa - sb - cin;
            cout = (a >= b + cin);
        end
        ovf = (r < -half) || (r >= half);
        sm  = ((u % m) + m) % m;
        return 32'(sm) | (32'(ovf) << w) | (32'(cout) << (w + 1));
    endfunction

    // ---------------- directed WIDTH=8, STAGES=2 ----------------
    logic       d_rst, d_in_valid, d_in_ready, d_Cin, d_sub, d_out_valid, d_out_ready, d_Cout, d_Ovf;
    logic [7:0] d_A, d_B, d_Sum;

    adder_pipe #(.WIDTH(8), .STAGES(2)) dut_dir (
        .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .A(d_A), .B(d_B), .Cin(d_Cin), .sub(d_sub),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .Sum(d_Sum), .Cout(d_Cout), .Ovf(d_Ovf)
    );

    task automatic dir_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic s,
                           input logic [7:0] es, input logic ec, input logic eo);
        d_A = a; d_B = b; d_Cin = cin; d_sub = s; d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, d_in_ready, 1);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, d_out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_lat2"}, d_out_valid, 1);
        chk({tag, "_res"}, 32'({d_Cout, d_Ovf, d_Sum}), 32'({ec, eo, es}));
        chk({tag, "_model"}, 32'({d_Cout, d_Ovf, d_Sum}), ref_result(8, int'(a), int'(b), int'(cin), int'(s)));
        @(posedge clk); #1;
    endtask

    // ---------------- exhaustive WIDTH=4 sweeps ----------------
    localparam int CFG_STAGES [3] = '{1, 2, 4};

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int ST = CFG_STAGES[g];

        logic       rst, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, Ovf;
        logic [3:0] A, B, Sum;
        logic [31:0] q[$];
        bit done = 1'b0;

        adder_pipe #(.WIDTH(4), .STAGES(ST)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .A(A), .B(B), .Cin(Cin), .sub(sub),
            .out_valid(out_valid), .out_ready(out_ready),
            .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
        );

        // Monitor: scoreboard pops on consume, pushes on accept, flushes on reset.
        initial begin
            logic [31:0] obs, held_val;
            bit rst_prev, held_prev;
            rst_prev = 1'b0; held_prev = 1'b0; held_val = '0;
            forever begin
                @(negedge clk);
                obs = 32'({Cout, Ovf, Sum});
                if (rst_prev) begin
                    chk("rst_ovld", out_valid, 0);
                end else if (held_prev) begin
                    chk("hold_vld", out_valid, 1);
                    chk("hold_dat", obs, held_val);
                end
                if (!rst && q.size() == 0) chk("stale", out_valid, 0);
                chk("in_ready", in_ready, 32'(!out_valid || out_ready));
                if (out_valid && out_ready && q.size() != 0) chk("result", obs, q.pop_front());
                held_prev = out_valid && !out_ready;
                held_val  = obs;
                if (rst) q.delete();
                else if (in_valid && in_ready)
                    q.push_back(ref_result(4, int'(A), int'(B), int'(Cin), int'(sub)));
                rst_prev = rst;
            end
        end

        initial begin
            bit acc;
            int guard;
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("rst_out", 32'({out_valid, Cout, Ovf, Sum}), 0);
            chk("rst_in_ready", in_ready, 1);
            @(posedge clk); #1;
            for (int i = 0; i < 1024; i++) begin
                if (i == 600) begin
                    rst = 1'b1;
                    in_valid  = 1'($urandom_range(0, 1));
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    rst = 1'b0;
                end
                while ($urandom_range(0, 3) == 0) begin
                    in_valid  = 1'b0;
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                A = i[3:0]; B = i[7:4]; Cin = i[8]; sub = i[9];
                in_valid  = 1'b1;
                out_ready = 1'($urandom_range(0, 1));
                acc = 1'b0;
                guard = 0;
                while (!acc && guard < 50) begin
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                    guard++;
                end
                chk("accept", acc, 1);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
            #1;
            chk("drain", q.size(), 0);
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        d_rst = 1'b1; d_in_valid = 1'b0; d_out_ready = 1'b1;
        d_A = '0; d_B = '0; d_Cin = 1'b0; d_sub = ADD;
        repeat (2) @(posedge clk);
        #1 d_rst = 1'b0;
        @(negedge clk);
        chk("d_rst_out", 32'({d_out_valid, d_Cout, d_Ovf, d_Sum}), 0);
        chk("d_rst_in_ready", d_in_ready, 1);
        @(posedge clk); #1;

        dir_vec("add7f",  8'h7F, 8'h01, 1'b0, ADD, 8'h80, 1'b0, 1'b1);
        dir_vec("addff",  8'hFF, 8'h00, 1'b1, ADD, 8'h00, 1'b1, 1'b0);
        dir_vec("sub57",  8'h05, 8'h07, 1'b0, SUB, 8'hFE, 1'b0, 1'b0);
        dir_vec("sub80",  8'h80, 8'h01, 1'b0, SUB, 8'h7F, 1'b1, 1'b1);

        // Backpressure: three beats, consumer stalls four cycles after the first result.
        d_A = 8'h10; d_B = 8'h01; d_Cin = 1'b0; d_sub = ADD; d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(posedge clk); #1;
        d_A = 8'h20; d_B = 8'h02; d_out_ready = 1'b0;
        @(posedge clk); #1;
        d_A = 8'h30; d_B = 8'h03;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_ovld", d_out_valid, 1);
            chk("bp_in_ready", d_in_ready, 0);
            chk("bp_hold", d_Sum, 8'h11);
            @(posedge clk); #1;
        end
        d_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_r0_vld", d_out_valid, 1);
        chk("bp_r0", d_Sum, 8'h11);
        chk("bp_r0_in_ready", d_in_ready, 1);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_r1_vld", d_out_valid, 1);
        chk("bp_r1", d_Sum, 8'h22);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_r2_vld", d_out_valid, 1);
        chk("bp_r2", d_Sum, 8'h33);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_empty", d_out_valid, 0);

        for (int c = 0; c < 40000; c++) begin
            if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
            @(posedge clk);
        end
        chk("complete", 32'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done}), 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
